// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and data memory signals of the load/store unit
interface load_store_unit_if #(parameter int WIDTH = 32);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;
    logic             mem_we;
    logic             mem_type;
    logic [WIDTH-1:0] mem_a;
    logic [WIDTH-1:0] mem_wd;
    logic [WIDTH-1:0] mem_rd;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_type, mem_a, mem_wd
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_type, mem_a, mem_wd
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: sequences one RV32I load/store into byte/word data memory accesses
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC0 = 2'd1;
    localparam logic [1:0] ACC1 = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]       state;
    logic             we;
    logic [2:0]       f3;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [7:0]       dat;
    logic [WIDTH-1:0] rdata;
    logic             err;
    logic             req_illegal;
    logic             half;

    // funct3 is known legal here: bit1 selects word, bit0 halfword, bit2 unsigned
    function automatic logic [WIDTH-1:0] ext(input logic [2:0] f, input logic [WIDTH-1:0] v);
        return f[1] ? v :
               f[0] ? {{(WIDTH-16){~f[2] & v[15]}}, v[15:0]} :
                      {{(WIDTH-8){~f[2] & v[7]}}, v[7:0]};
    endfunction

    assign req_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
                         (bus.req_we && bus.req_funct3[2]);
    assign half        = f3[1:0] == 2'b01;

    assign bus.req_ready  = state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.resp_rdata = rdata;
    assign bus.resp_err   = err;

    // memory port is driven only during the access states, zero otherwise
    always_comb begin
        bus.mem_we   = (state == ACC0 || state == ACC1) && we;
        bus.mem_type = state == ACC1 || (state == ACC0 && f3 != 3'b010);
        bus.mem_a    = state == ACC0 ? addr : state == ACC1 ? addr + WIDTH'(1) : '0;
        bus.mem_wd   = state == ACC0 ? (f3 == 3'b010 ? wdata : {{(WIDTH-8){1'b0}}, wdata[7:0]}) :
                       state == ACC1 ? {{(WIDTH-8){1'b0}}, wdata[15:8]} : '0;
    end

    // request latch, access sequencing and response register update on entering RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            we    <= 1'b0;
            f3    <= '0;
            addr  <= '0;
            wdata <= '0;
            dat   <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    we    <= bus.req_we;
                    f3    <= bus.req_funct3;
                    addr  <= bus.req_addr;
                    wdata <= bus.req_wdata;
                    state <= req_illegal ? RESP : ACC0;
                    if (req_illegal) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end
                end
                ACC0: begin
                    if (!we) dat <= bus.mem_rd[7:0];
                    state <= half ? ACC1 : RESP;
                    if (!half) begin
                        rdata <= we ? '0 : ext(f3, bus.mem_rd);
                        err   <= 1'b0;
                    end
                end
                ACC1: begin
                    rdata <= we ? '0 : ext(f3, {{(WIDTH-16){1'b0}}, bus.mem_rd[7:0], dat});
                    err   <= 1'b0;
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
